// File: rtl/xge_rx_pkt_checker_if.sv
// Receive packet bus between the 10G MAC RX FIFO and a packet consumer.
// The MAC side drives the word stream; the consumer drives the read enable.
interface xge_rx_pkt_checker_if;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic        pkt_rx_val;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;

    modport master (
        output pkt_rx_avail,
        output pkt_rx_val,
        output pkt_rx_data,
        output pkt_rx_sop,
        output pkt_rx_eop,
        output pkt_rx_mod,
        output pkt_rx_err,
        input  pkt_rx_ren
    );

    modport slave (
        input  pkt_rx_avail,
        input  pkt_rx_val,
        input  pkt_rx_data,
        input  pkt_rx_sop,
        input  pkt_rx_eop,
        input  pkt_rx_mod,
        input  pkt_rx_err,
        output pkt_rx_ren
    );
endinterface

// File: rtl/xge_rx_pkt_checker.sv
// Loopback packet checker for the 10G MAC receive port.
// Reads whole packets out of the MAC RX FIFO, checks framing, the
// incrementing-byte payload, the expected length and the MAC error flag,
// and keeps saturating packet / error counters.
module xge_rx_pkt_checker #(
    parameter int CNT_W = 32,
    parameter int LEN_W = 16
) (
    input  logic                 clk_156m25,
    input  logic                 reset_156m25,
    xge_rx_pkt_checker_if.slave  rx,
    input  logic [LEN_W-1:0]     exp_len,
    input  logic                 err_clr,
    output logic                 pkt_done,
    output logic                 pkt_err,
    output logic [LEN_W-1:0]     last_len,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ren_q, ren_d;
    logic               flag_q, flag_d;
    logic [LEN_W-1:0]   bidx_q, bidx_d;
    logic [LEN_W-1:0]   last_len_q, last_len_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               pkt_inc;
    logic               err_inc;

    logic [3:0]         word_nb;
    logic [LEN_W-1:0]   word_len;
    logic               word_first;
    logic               word_frame_bad;
    logic               word_data_bad;
    logic               word_tail_bad;
    logic               word_bad;

    // Number of meaningful bytes in a word: full unless it is the eop word,
    // where mod gives the count and 0 stands for a full word.
    function automatic logic [3:0] valid_bytes(input logic eop, input logic [2:0] mod);
        if (eop && (mod != 3'd0)) begin
            return {1'b0, mod};
        end
        return 4'd8;
    endfunction

    // Byte index accumulation; pins at all-ones instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                                 input logic [3:0]       b);
        logic [LEN_W:0] s;
        s = {1'b0, a} + (LEN_W+1)'(b);
        if (s[LEN_W]) begin
            return '1;
        end
        return s[LEN_W-1:0];
    endfunction

    // Counter step that holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == '1) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    // Compares the first nb bytes of a word against the incrementing
    // pattern starting at base; byte 0 sits in the top byte lane.
    function automatic logic payload_bad(input logic [63:0] data,
                                         input logic [7:0]  base,
                                         input logic [3:0]  nb);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ((4'(k) < nb) && (data[63-8*k -: 8] != (base + 8'(k)))) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Per-word checks; only consumed while reading a packet.
    always_comb begin
        word_nb        = valid_bytes(rx.pkt_rx_eop, rx.pkt_rx_mod);
        word_len       = sat_add(bidx_q, word_nb);
        // A packet always advances bidx by at least one byte per word, so a
        // zero index means no word of this packet has been seen yet.
        word_first     = (bidx_q == '0);
        word_frame_bad = word_first ? !rx.pkt_rx_sop : rx.pkt_rx_sop;
        word_data_bad  = payload_bad(rx.pkt_rx_data, bidx_q[7:0], word_nb);
        word_tail_bad  = rx.pkt_rx_eop &&
                         (rx.pkt_rx_err || ((exp_len != '0) && (word_len != exp_len)));
        word_bad       = word_frame_bad || word_data_bad || word_tail_bad;
    end

    // Next-state, per-packet bookkeeping and counter increments.
    always_comb begin
        state_d    = state_q;
        flag_d     = flag_q;
        bidx_d     = bidx_q;
        last_len_d = last_len_q;
        pkt_inc    = 1'b0;
        err_inc    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Data offered while no packet is being read is an orphan.
                if (rx.pkt_rx_val) begin
                    err_inc = 1'b1;
                end
                if (rx.pkt_rx_avail) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (rx.pkt_rx_val) begin
                    flag_d = flag_q || word_bad;
                    bidx_d = word_len;
                    if (rx.pkt_rx_eop) begin
                        // Completion results are registered here so they are
                        // all visible together during the DONE cycle.
                        state_d    = DONE;
                        last_len_d = word_len;
                        pkt_inc    = 1'b1;
                        err_inc    = flag_q || word_bad;
                    end
                end
            end
            DONE: begin
                if (rx.pkt_rx_val) begin
                    err_inc = 1'b1;
                end
                flag_d  = 1'b0;
                bidx_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ren_d = (state_d == READ);

        // Clear wins over any increment landing in the same cycle.
        if (err_clr) begin
            pkt_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            pkt_cnt_d = pkt_inc ? sat_inc(pkt_cnt_q) : pkt_cnt_q;
            err_cnt_d = err_inc ? sat_inc(err_cnt_q) : err_cnt_q;
        end
    end

    // State and bookkeeping registers; reset aborts any packet in flight.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state_q    <= IDLE;
            ren_q      <= 1'b0;
            flag_q     <= 1'b0;
            bidx_q     <= '0;
            last_len_q <= '0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ren_q      <= ren_d;
            flag_q     <= flag_d;
            bidx_q     <= bidx_d;
            last_len_q <= last_len_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rx.pkt_rx_ren = ren_q;
    assign pkt_done      = (state_q == DONE);
    assign pkt_err       = (state_q == DONE) && flag_q;
    assign last_len      = last_len_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_xge_rx_pkt_checker.sv
// Directed bench for xge_rx_pkt_checker: a table of packets with
// hand-computed results, followed by sequences for back-to-back timing,
// orphans, counter clear, saturation and mid-packet reset.
module tb_xge_rx_pkt_checker;

    logic        clk;
    logic        rst;
    logic [15:0] exp_len;
    logic        err_clr;
    logic        pkt_done;
    logic        pkt_err;
    logic [15:0] last_len;
    logic [3:0]  pkt_cnt;
    logic [3:0]  err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    xge_rx_pkt_checker_if rx_if ();

    xge_rx_pkt_checker #(.CNT_W(4), .LEN_W(16)) dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .rx           (rx_if),
        .exp_len      (exp_len),
        .err_clr      (err_clr),
        .pkt_done     (pkt_done),
        .pkt_err      (pkt_err),
        .last_len     (last_len),
        .pkt_cnt      (pkt_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          len;
        logic [15:0] elen;
        int          c1;
        int          c2;
        bit          no_sop;
        bit          mac_err;
        bit          extra_sop;
        bit          gap;
        bit          e_err;
        logic [15:0] e_len;
        logic [3:0]  e_pkt;
        logic [3:0]  e_errc;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_word(input vec_t v, input int w);
        logic [63:0] d;
        logic [7:0]  b;
        int          idx;
        d = '0;
        for (int k = 0; k < 8; k++) begin
            idx = 8 * w + k;
            b = (idx < v.len) ? 8'(idx) : 8'hA5;
            if (idx == v.c1 || idx == v.c2) b = 8'hFF;
            d[63-8*k -: 8] = b;
        end
        return d;
    endfunction

    // Raise avail and wait (bounded) for the read enable.
    task automatic wait_ren(input string name, output bit ok);
        int n;
        rx_if.pkt_rx_avail = 1'b1;
        n = 0;
        while (!rx_if.pkt_rx_ren && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(rx_if.pkt_rx_ren), 32'd1);
        ok = rx_if.pkt_rx_ren;
    endtask

    // Drives one packet; returns at the cycle after the eop word.
    task automatic send_pkt(input vec_t v, input bit keep_avail);
        int nw;
        bit ok;
        exp_len = v.elen;
        wait_ren("ren_wait", ok);
        if (!keep_avail) rx_if.pkt_rx_avail = 1'b0;
        if (!ok) return;
        nw = (v.len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            if (v.gap && w == 1) begin
                rx_if.pkt_rx_val = 1'b0;
                tick();
                tick();
            end
            rx_if.pkt_rx_val  = 1'b1;
            rx_if.pkt_rx_data = mk_word(v, w);
            rx_if.pkt_rx_sop  = ((w == 0) && !v.no_sop) || (v.extra_sop && w == 1);
            rx_if.pkt_rx_eop  = (w == nw - 1);
            rx_if.pkt_rx_mod  = (w == nw - 1) ? 3'(v.len % 8) : 3'd0;
            rx_if.pkt_rx_err  = v.mac_err && (w == nw - 1);
            tick();
        end
        rx_if.pkt_rx_val = 1'b0;
        rx_if.pkt_rx_sop = 1'b0;
        rx_if.pkt_rx_eop = 1'b0;
        rx_if.pkt_rx_err = 1'b0;
        rx_if.pkt_rx_mod = 3'd0;
    endtask

    initial begin
        vec_t g;
        vec_t bad8;
        bit   ok;
        bit   saw_done;

        rst = 1'b1;
        err_clr = 1'b0;
        exp_len = '0;
        rx_if.pkt_rx_avail = 1'b0;
        rx_if.pkt_rx_val   = 1'b0;
        rx_if.pkt_rx_data  = '0;
        rx_if.pkt_rx_sop   = 1'b0;
        rx_if.pkt_rx_eop   = 1'b0;
        rx_if.pkt_rx_mod   = 3'd0;
        rx_if.pkt_rx_err   = 1'b0;
        repeat (3) tick();

        chk("rst_ren",      32'(rx_if.pkt_rx_ren), 32'd0);
        chk("rst_done",     32'(pkt_done), 32'd0);
        chk("rst_err",      32'(pkt_err),  32'd0);
        chk("rst_last_len", 32'(last_len), 32'd0);
        chk("rst_pkt_cnt",  32'(pkt_cnt),  32'd0);
        chk("rst_err_cnt",  32'(err_cnt),  32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ren", 32'(rx_if.pkt_rx_ren), 32'd0);

        //            len elen    c1  c2 nosop mac  xsop gap  e_err e_len  pkt   errc
        vecs[0]  = '{64, 16'd64, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd64, 4'd1,  4'd0};
        vecs[1]  = '{61, 16'd61, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd61, 4'd2,  4'd0};
        vecs[2]  = '{3,  16'd3,  -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3,  4'd3,  4'd0};
        vecs[3]  = '{64, 16'd0,  17, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd64, 4'd4,  4'd1};
        vecs[4]  = '{40, 16'd0,   3, 30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd40, 4'd5,  4'd2};
        vecs[5]  = '{16, 16'd16, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd16, 4'd6,  4'd3};
        vecs[6]  = '{24, 16'd24, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd24, 4'd7,  4'd4};
        vecs[7]  = '{64, 16'd60, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd64, 4'd8,  4'd5};
        vecs[8]  = '{20, 16'd20, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd20, 4'd9,  4'd5};
        vecs[9]  = '{24, 16'd0,  -1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd24, 4'd10, 4'd6};
        vecs[10] = '{9,  16'd9,  -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9,  4'd11, 4'd6};

        for (int i = 0; i < 11; i++) begin
            send_pkt(vecs[i], 1'b0);
            chk($sformatf("v%0d_done", i),     32'(pkt_done), 32'd1);
            chk($sformatf("v%0d_err", i),      32'(pkt_err),  32'(vecs[i].e_err));
            chk($sformatf("v%0d_last_len", i), 32'(last_len), 32'(vecs[i].e_len));
            chk($sformatf("v%0d_pkt_cnt", i),  32'(pkt_cnt),  32'(vecs[i].e_pkt));
            chk($sformatf("v%0d_err_cnt", i),  32'(err_cnt),  32'(vecs[i].e_errc));
            chk($sformatf("v%0d_ren_low", i),  32'(rx_if.pkt_rx_ren), 32'd0);
            tick();
            chk($sformatf("v%0d_pulse", i),    32'(pkt_done), 32'd0);
        end

        // Back-to-back packets with avail held high: two ren-low cycles.
        g = '{16, 16'd16, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd16, 4'd12, 4'd6};
        send_pkt(g, 1'b1);
        chk("b2b_done",     32'(pkt_done), 32'd1);
        chk("b2b_ren_done", 32'(rx_if.pkt_rx_ren), 32'd0);
        tick();
        chk("b2b_ren_idle", 32'(rx_if.pkt_rx_ren), 32'd0);
        tick();
        chk("b2b_ren_back", 32'(rx_if.pkt_rx_ren), 32'd1);
        g = '{8, 16'd8, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8, 4'd13, 4'd6};
        send_pkt(g, 1'b0);
        chk("b2b2_done",     32'(pkt_done), 32'd1);
        chk("b2b2_last_len", 32'(last_len), 32'd8);
        chk("b2b2_pkt_cnt",  32'(pkt_cnt),  32'd13);
        tick();

        // Clear while idle.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_pkt_cnt",  32'(pkt_cnt),  32'd0);
        chk("clr_err_cnt",  32'(err_cnt),  32'd0);
        chk("clr_last_len", 32'(last_len), 32'd8);

        // Two orphan words while idle.
        rx_if.pkt_rx_val  = 1'b1;
        rx_if.pkt_rx_data = 64'h0001020304050607;
        rx_if.pkt_rx_sop  = 1'b1;
        tick();
        tick();
        rx_if.pkt_rx_val = 1'b0;
        rx_if.pkt_rx_sop = 1'b0;
        chk("orph_err_cnt", 32'(err_cnt), 32'd2);
        chk("orph_pkt_cnt", 32'(pkt_cnt), 32'd0);
        chk("orph_ren",     32'(rx_if.pkt_rx_ren), 32'd0);

        // Clear coincident with an errored DONE plus an orphan word.
        bad8 = '{8, 16'd8, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd8, 4'd1, 4'd3};
        send_pkt(bad8, 1'b0);
        chk("cd_err",     32'(pkt_err), 32'd1);
        chk("cd_err_cnt", 32'(err_cnt), 32'd3);
        err_clr = 1'b1;
        rx_if.pkt_rx_val = 1'b1;
        tick();
        err_clr = 1'b0;
        rx_if.pkt_rx_val = 1'b0;
        chk("cd_pkt_cnt",  32'(pkt_cnt),  32'd0);
        chk("cd_err_cnt0", 32'(err_cnt),  32'd0);
        chk("cd_last_len", 32'(last_len), 32'd8);

        // Saturation: 20 errored packets into 4-bit counters.
        for (int i = 0; i < 20; i++) begin
            send_pkt(bad8, 1'b0);
            if (i == 16) chk("sat_err_cnt_17", 32'(err_cnt), 32'd15);
        end
        chk("sat_err_cnt", 32'(err_cnt), 32'd15);
        chk("sat_pkt_cnt", 32'(pkt_cnt), 32'd15);
        tick();

        // Reset arriving with the eop word of a packet in flight.
        g = '{16, 16'd16, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd16, 4'd0, 4'd0};
        exp_len = 16'd16;
        wait_ren("rst_ren_wait", ok);
        rx_if.pkt_rx_avail = 1'b0;
        if (ok) begin
            rx_if.pkt_rx_val  = 1'b1;
            rx_if.pkt_rx_data = mk_word(g, 0);
            rx_if.pkt_rx_sop  = 1'b1;
            tick();
            rx_if.pkt_rx_data = mk_word(g, 1);
            rx_if.pkt_rx_sop  = 1'b0;
            rx_if.pkt_rx_eop  = 1'b1;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            rx_if.pkt_rx_val = 1'b0;
            rx_if.pkt_rx_eop = 1'b0;
        end
        chk("mid_rst_ren",      32'(rx_if.pkt_rx_ren), 32'd0);
        chk("mid_rst_done",     32'(pkt_done), 32'd0);
        chk("mid_rst_err",      32'(pkt_err),  32'd0);
        chk("mid_rst_last_len", 32'(last_len), 32'd0);
        chk("mid_rst_pkt_cnt",  32'(pkt_cnt),  32'd0);
        chk("mid_rst_err_cnt",  32'(err_cnt),  32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            tick();
            saw_done |= pkt_done;
        end
        chk("mid_rst_no_done", 32'(saw_done), 32'd0);

        // Normal operation resumes after the aborted packet.
        g = '{8, 16'd8, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8, 4'd1, 4'd0};
        send_pkt(g, 1'b0);
        chk("post_rst_done",    32'(pkt_done), 32'd1);
        chk("post_rst_err",     32'(pkt_err),  32'd0);
        chk("post_rst_pkt_cnt", 32'(pkt_cnt),  32'd1);
        chk("post_rst_err_cnt", 32'(err_cnt),  32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/xge_rx_pkt_checker.md
# xge_rx_pkt_checker

Self-checking consumer for the 10G MAC receive packet interface, sitting directly downstream of the MAC's `pkt_rx_*` port in the loopback test environment. It pulls packets out of the MAC RX FIFO using the `pkt_rx_ren`/`pkt_rx_avail` handshake. Each packet is checked for framing, incrementing-byte payload, expected length and the MAC error flag. It keeps saturating packet and error counters that the bench reads and clears in place of software bookkeeping.

## Interface
Parameters:
- `CNT_W`, default 32: width of `pkt_cnt` and `err_cnt`.
- `LEN_W`, default 16: width of the length accumulator, `exp_len` and `last_len`.

Ports:
- `clk_156m25`, in, 1: core clock.
- `reset_156m25`, in, 1: synchronous, active-high reset.
- `pkt_rx_avail`, in, 1: MAC has at least one complete packet buffered.
- `pkt_rx_ren`, out, 1: read enable to the MAC; registered.
- `pkt_rx_val`, in, 1: data word valid this cycle.
- `pkt_rx_data`, in, 64: packet word; byte 0 is `[63:56]`.
- `pkt_rx_sop`, in, 1: first word of the packet.
- `pkt_rx_eop`, in, 1: last word of the packet.
- `pkt_rx_mod`, in, 3: valid bytes in the eop word; 0 means 8.
- `pkt_rx_err`, in, 1: MAC-flagged bad packet; sampled on the eop word.
- `exp_len`, in, `LEN_W`: expected byte length; 0 disables the length check.
- `err_clr`, in, 1: one-cycle pulse that zeroes `err_cnt` and `pkt_cnt`.
- `pkt_done`, out, 1: one-cycle pulse when a packet completes.
- `pkt_err`, out, 1: one-cycle pulse, coincident with `pkt_done`, when the completed packet failed any check.
- `last_len`, out, `LEN_W`: byte length of the most recently completed packet.
- `pkt_cnt`, out, `CNT_W`: completed packets; saturating.
- `err_cnt`, out, `CNT_W`: errored packets plus orphan words; saturating.

## Operation
- State machine states are IDLE, READ and DONE. Reset forces IDLE, and every output is 0.
- IDLE → READ when `pkt_rx_avail`=1. `pkt_rx_ren`=1 exactly while in READ.
- In READ, each `pkt_rx_val` word is processed as follows:
  - A byte counter `bidx` (`LEN_W` bits) tracks the packet byte index.
  - Expected byte k is `(bidx+k) mod 256`.
  - Every valid byte is compared: all 8 bytes on non-eop words, the first `mod` bytes (or 8 when `mod`=0) on the eop word. Bytes beyond `mod` are ignored.
  - `bidx` advances by the number of valid bytes and saturates at all-ones.
- A sticky per-packet error flag is set by any of these:
  - the first valid word in READ lacks `sop`;
  - `sop` appears on any later word;
  - any byte mismatches;
  - `pkt_rx_err`=1 on the eop word;
  - `exp_len`≠0 and the final length ≠ `exp_len`. `exp_len` is sampled on the eop word.
- A word with `sop`=1 and `eop`=1 together is a legal single-word packet.
- READ → DONE on a valid word with `eop`=1.
- In DONE:
  - `pkt_done`=1; `pkt_err` equals the sticky flag.
  - `last_len` takes the final length.
  - `pkt_cnt` increments; `err_cnt` increments by 1 if the flag is set, at most once per packet.
  - Flag and `bidx` clear, then → IDLE.
- Orphan word: `pkt_rx_val`=1 while in IDLE or DONE. The word is otherwise ignored and `err_cnt` increments by 1.
- Both counters saturate at all-ones and never wrap.
- `err_clr` takes priority over every increment in the same cycle: both counters read 0 the next cycle. It does not alter state, the flag or `last_len`.
- Reset during READ aborts the packet: no `pkt_done` pulse and no counter update.

## Timing
- The path from the `pkt_rx_avail` edge to `pkt_rx_ren`=1 is 1 cycle.
- `pkt_rx_ren` falls in the cycle after the eop word is sampled.
- `pkt_done`, `pkt_err`, `last_len` and the counters all update 1 cycle after the eop word.
- After DONE the block returns to IDLE. If `pkt_rx_avail` is still high, `pkt_rx_ren` reasserts 2 cycles after DONE, giving a minimum inter-packet gap of 2 cycles with ren low.
- The block never stalls mid-packet: gaps with `pkt_rx_val`=0 while in READ are tolerated indefinitely.

## Test plan
- **Good packet:** a 64-byte incrementing packet, 8 words, `mod`=0, `exp_len`=64 → one `pkt_done` pulse, `pkt_err`=0, `last_len`=64, `pkt_cnt`=1, `err_cnt`=0.
- **Short eop and single-word packet:**
  - 61-byte packet, `mod`=5, `exp_len`=61, garbage in bytes 5–7 of the last word → `pkt_err`=0, `last_len`=61.
  - Then a single word with sop+eop and `mod`=3 → `last_len`=3, `pkt_cnt`=2.
- **Payload corruption:** byte 17 set to 0xFF, `exp_len`=0 → `pkt_err`=1, `err_cnt`=1. Two corrupted bytes in one packet still give `err_cnt`=1.
- **Framing, MAC and length errors:**
  - Missing sop → `err_cnt`+1.
  - `pkt_rx_err`=1 on eop → `err_cnt`+1.
  - 64-byte packet with `exp_len`=60 → `err_cnt`+1.
  - Total `err_cnt`=3, `pkt_cnt`=3.
- **Orphans and clear:**
  - Two `pkt_rx_val` words while IDLE → `err_cnt`=2.
  - `err_clr` asserted in the same cycle as a DONE with error → both counters read 0 the next cycle.
- **Saturation and reset:**
  - Force `err_cnt` near all-ones via `CNT_W`=4 and 20 bad packets → `err_cnt` holds at 15.
  - Assert `reset_156m25` mid-READ → `pkt_rx_ren`=0 and all outputs 0 the next cycle, with no `pkt_done` pulse.
